// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory reads and
// fills the IF/ID latch. Handles hazard stalls, downstream redirects
// (branch/jal/jr) and a halt opcode that freezes fetch until reset or until
// a redirect squashes the path the halt was fetched on.
module fetch_stage #(
    parameter logic [31:0] PC_INIT     = 32'h0000_0000,
    parameter logic [5:0]  HALT_OPCODE = 6'h3F
) (
    input  logic        CLK,
    input  logic        nRST,

    // instruction memory
    input  logic        ihit,
    input  logic [31:0] iload,
    output logic        iREN,
    output logic [31:0] iaddr,

    // hazard / redirect control
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,

    // IF/ID latch
    output logic [31:0] if_id_imemload,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,

    // status
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] imemload;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic        valid;
    } if_id_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    if_id_t      if_id_q, if_id_d;
    logic [31:0] count_q, count_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_aligned;
    logic        is_halt;
    if_id_t      fetched;

    // Datapath helpers shared by the next-state logic
    always_comb begin
        pc_plus4         = pc_q + 32'd4;
        redirect_aligned = redirect_pc & ~32'd3;
        is_halt          = (iload[31:26] == HALT_OPCODE);
        fetched.imemload = iload;
        fetched.pc       = pc_q;
        fetched.pc4      = pc_plus4;
        fetched.valid    = 1'b1;
    end

    // Next-state logic: redirect > stall > ihit > miss while running;
    // in HALTED only a redirect restarts fetch
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if_id_d = if_id_q;
        count_d = count_q;

        unique case (state_q)
            RUN: begin
                if (redirect) begin
                    pc_d    = redirect_aligned;
                    if_id_d = '0;
                end else if (stall) begin
                    // hold everything; a concurrent hit is refetched later
                end else if (ihit) begin
                    if_id_d = fetched;
                    count_d = count_q + 32'd1;
                    if (is_halt) begin
                        state_d = HALTED;
                    end else begin
                        pc_d = pc_plus4;
                    end
                end else begin
                    if_id_d = '0;
                end
            end

            HALTED: begin
                if (redirect) begin
                    pc_d    = redirect_aligned;
                    if_id_d = '0;
                    state_d = RUN;
                end else if (!stall) begin
                    if_id_d = '0;
                end
            end

            default: begin
                state_d = RUN;
            end
        endcase
    end

    // State, PC, IF/ID latch and delivered-instruction counter
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
            pc_q    <= PC_INIT;
            if_id_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
            count_q <= count_d;
        end
    end

    // Output mapping
    always_comb begin
        iREN           = (state_q == RUN);
        iaddr          = pc_q;
        halted         = (state_q == HALTED);
        if_id_imemload = if_id_q.imemload;
        if_id_pc       = if_id_q.pc;
        if_id_pc4      = if_id_q.pc4;
        if_id_valid    = if_id_q.valid;
        fetch_count    = count_q;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline.
- Owns the PC register and drives the instruction-memory request (iREN/iaddr; response on ihit/iload).
- Produces the IF/ID latch contents consumed by decode: imemload, pc, pc4, plus a valid flag.
- Accepts stall from the hazard unit and PC redirects (branch/jump/jr resolved downstream). Handles halt by freezing fetch.

Parameters:
- PC_INIT, 32'h00000000, PC value loaded on reset.
- HALT_OPCODE, 6'h3F, opcode field (imemload[31:26]) that puts the stage into HALTED.

Ports:
- CLK  in  1  system clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- ihit  in  1  instruction memory returned iload for iaddr this cycle.
- iload  in  32  instruction word from memory.
- iREN  out  1  instruction read enable.
- iaddr  out  32  instruction fetch address (= PC).
- stall  in  1  hold PC and IF/ID (hazard unit).
- redirect  in  1  take redirect_pc; squash the current fetch.
- redirect_pc  in  32  new PC target (branch, jal, jr).
- if_id_imemload  out  32  latched instruction.
- if_id_pc  out  32  PC of the latched instruction.
- if_id_pc4  out  32  if_id_pc + 4.
- if_id_valid  out  1  latched instruction is real (0 = bubble/NOP).
- halted  out  1  stage is in HALTED.
- fetch_count  out  32  count of instructions delivered to IF/ID.

Behaviour:
- Reset (async, nRST=0): pc=PC_INIT; all if_id_* = 0; state=RUN; fetch_count=0. The stage leaves reset on the first CLK edge after nRST rises.
- States: RUN, HALTED.
- In RUN, iREN=1. In HALTED, iREN=0. iaddr=pc always. halted=(state==HALTED).
- Per-edge priority in RUN: redirect > stall > ihit > miss.
  - redirect=1: pc <= {redirect_pc[31:2],2'b00}; IF/ID <= bubble (all zero, valid=0). Any concurrent ihit is discarded. This holds even when stall=1.
  - stall=1 (no redirect): pc and IF/ID hold. A concurrent ihit is dropped, and the same address is refetched later.
  - ihit=1: IF/ID <= {iload, pc, pc+4}; valid=1; fetch_count+1; pc <= pc+4.
    - If iload[31:26]==HALT_OPCODE: pc holds (not incremented) and state -> HALTED.
  - ihit=0: IF/ID <= bubble; pc holds.
- In HALTED:
  - No fetch requests are issued.
  - On !stall, IF/ID <= bubble. On stall, IF/ID holds so the halt instruction still reaches decode.
  - redirect=1 in HALTED (the halt was on a squashed path): pc <= redirect_pc with low bits cleared; IF/ID <= bubble; state -> RUN.
  - Otherwise the stage remains in HALTED until reset.
- Arithmetic:
  - pc+4 is 32-bit modular: 32'hFFFFFFFC -> 32'h00000000.
  - fetch_count wraps at 2^32.
  - Bubble outputs are exactly zero (all if_id_* = 0), which is sll $0,$0,0.
- Latency: an instruction appears on if_id_* the cycle after its ihit edge. Redirect takes effect on iaddr the cycle after the redirect edge.
- Reset mid-operation (incl. HALTED or stalled): immediate return to reset values. No pending state survives reset.

Test Plan:
- Sequential fetch: reset with PC_INIT=0; ihit=1 every cycle with iload=addr-tagged words → iaddr 0,4,8,C on successive cycles; if_id_pc lags iaddr by one cycle; if_id_pc4=if_id_pc+4; fetch_count=4 after 4 hits.
- Miss and stall: ihit=0 for 2 cycles at pc=8 → iaddr stays 8, if_id_valid=0 for both cycles. Then stall=1 with ihit=1 → IF/ID and pc frozen, fetch_count unchanged.
- Redirect priority: at pc=0x10, assert redirect=1, redirect_pc=0x40, stall=1, ihit=1 → next iaddr=0x40, if_id_valid=0, fetch_count unchanged. redirect_pc=0x43 → iaddr=0x40.
- Halt: iload=0xFFFFFFFF at pc=0x20 with ihit → if_id_imemload=0xFFFFFFFF, valid=1; halted=1; iREN=0; pc stays 0x20. The next cycle's IF/ID is a bubble.
- Squashed halt: in HALTED, redirect=1, redirect_pc=0x100 → halted=0, iREN=1, iaddr=0x100.
- Wrap and async reset: pc=0xFFFFFFFC with ihit → pc=0; drop nRST mid-cycle → all outputs zero and iaddr=PC_INIT before the next CLK edge.
